vga_box_ctrl: RTL

Sequences the text-box renderers on the 640x480 display. It generates VGA timing and drives the shared cur_row/cur_col raster position to every box. It accepts character writes from requesters into a shadow buffer and commits that buffer to the active buffer only at the start of vertical blanking, so no box ever tears mid-frame. Box instances consume cur_row, cur_col and their slice of box_chars. The top level gates box pixels with visible.

---
 rtl/vga_timing_pkg.sv | 27 ++
 rtl/vga_timing.sv | 78 +++++++
 rtl/vga_box_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480 VGA timing constants and character encoding for the text-box controller.
// Derived sync windows are inclusive [start, end] counter ranges.
package vga_timing_pkg;

    localparam int SYMBOLS   = 4;
    localparam int BOXES     = 2;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;

    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START  = H_VISIBLE + H_FRONT;
    localparam int HS_END    = HS_START + H_SYNC - 1;
    localparam int VS_START  = V_VISIBLE + V_FRONT;
    localparam int VS_END    = VS_START + V_SYNC - 1;

    localparam int               CHAR_W     = 7;
    localparam logic [CHAR_W-1:0] CHAR_BLANK = 7'd0;

endpackage

// File: rtl/vga_timing.sv
// Raster counters and registered VGA outputs; commit_strobe marks the cycle whose
// counter state is (h=0, v=V_VISIBLE), i.e. the first cycle of vertical blanking.
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int H_BACK    = vga_timing_pkg::H_BACK,
    parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int V_BACK    = vga_timing_pkg::V_BACK
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       visible,
    output logic [8:0] cur_row,
    output logic [9:0] cur_col,
    output logic       frame_start,
    output logic       commit_strobe
);

    localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hCnt;
    logic [9:0] vCnt;
    logic       hWrap;
    logic       vWrap;
    logic       inVisible;

    assign hWrap         = (hCnt == H_LAST);
    assign vWrap         = (vCnt == V_LAST);
    assign inVisible     = (hCnt < H_VIS) && (vCnt < V_VIS);
    assign commit_strobe = (hCnt == 10'd0) && (vCnt == V_VIS);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hCnt <= '0;
            vCnt <= '0;
        end else if (hWrap) begin
            hCnt <= '0;
            vCnt <= vWrap ? '0 : vCnt + 10'd1;
        end else begin
            hCnt <= hCnt + 10'd1;
        end
    end

    // Outputs describe the counter state of the previous cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            visible     <= 1'b0;
            cur_row     <= '0;
            cur_col     <= '0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !((hCnt >= HS_FIRST) && (hCnt <= HS_LAST));
            vsync       <= !((vCnt >= VS_FIRST) && (vCnt <= VS_LAST));
            visible     <= inVisible;
            cur_row     <= inVisible ? vCnt[8:0] : 9'd0;
            cur_col     <= inVisible ? hCnt : 10'd0;
            frame_start <= (hCnt == 10'd0) && (vCnt == 10'd0);
        end
    end

endmodule

// File: rtl/vga_box_ctrl.sv
// Text-box sequencer: VGA timing plus shadow/active character buffers committed at vblank start.
// Optional VGA_BOX_FREEZE_EN adds a freeze input that postpones commits while high.
module vga_box_ctrl
    import vga_timing_pkg::*;
#(
    parameter int  SYMBOLS   = vga_timing_pkg::SYMBOLS,
    parameter int  BOXES     = vga_timing_pkg::BOXES,
    parameter int  H_VISIBLE = vga_timing_pkg::H_VISIBLE,
    parameter int  H_FRONT   = vga_timing_pkg::H_FRONT,
    parameter int  H_SYNC    = vga_timing_pkg::H_SYNC,
    parameter int  H_BACK    = vga_timing_pkg::H_BACK,
    parameter int  V_VISIBLE = vga_timing_pkg::V_VISIBLE,
    parameter int  V_FRONT   = vga_timing_pkg::V_FRONT,
    parameter int  V_SYNC    = vga_timing_pkg::V_SYNC,
    parameter int  V_BACK    = vga_timing_pkg::V_BACK,
    localparam int BOX_W     = (BOXES > 1) ? $clog2(BOXES) : 1,
    localparam int IDX_W     = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              wr_valid,
    output logic                              wr_ready,
    input  logic [BOX_W-1:0]                  wr_box,
    input  logic [IDX_W-1:0]                  wr_idx,
    input  logic [CHAR_W-1:0]                 wr_char,
    output logic                              hsync,
    output logic                              vsync,
    output logic                              visible,
    output logic [8:0]                        cur_row,
    output logic [9:0]                        cur_col,
    output logic                              frame_start,
    output logic [BOXES*SYMBOLS*CHAR_W-1:0]   box_chars,
`ifdef VGA_BOX_FREEZE_EN
    input  logic                              freeze,
`endif
    output logic                              commit_pending
);

    logic              commitStrobe;
    logic              freezeIn;
    logic              readyQ;
    logic              dirty;
    logic              wrFire;
    logic              wrInRange;
    logic [CHAR_W-1:0] shadowBuf [BOXES][SYMBOLS];
    logic [CHAR_W-1:0] activeBuf [BOXES][SYMBOLS];

    vga_timing #(
        .H_VISIBLE (H_VISIBLE),
        .H_FRONT   (H_FRONT),
        .H_SYNC    (H_SYNC),
        .H_BACK    (H_BACK),
        .V_VISIBLE (V_VISIBLE),
        .V_FRONT   (V_FRONT),
        .V_SYNC    (V_SYNC),
        .V_BACK    (V_BACK)
    ) uTiming (
        .clk           (clk),
        .reset_n       (reset_n),
        .hsync         (hsync),
        .vsync         (vsync),
        .visible       (visible),
        .cur_row       (cur_row),
        .cur_col       (cur_col),
        .frame_start   (frame_start),
        .commit_strobe (commitStrobe)
    );

`ifdef VGA_BOX_FREEZE_EN
    assign freezeIn = freeze;
`else
    assign freezeIn = 1'b0;
`endif

    assign wr_ready       = readyQ && !commitStrobe;
    assign wrFire         = wr_valid && wr_ready;
    assign wrInRange      = (32'(wr_box) < 32'(BOXES)) && (32'(wr_idx) < 32'(SYMBOLS));
    assign commit_pending = dirty;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readyQ <= 1'b0;
            dirty  <= 1'b0;
            // NOTE: these buffers are a handful of flops, so they take the async reset and a reset blanks every box.
            for (int b = 0; b < BOXES; b++) begin
                for (int s = 0; s < SYMBOLS; s++) begin
                    shadowBuf[b][s] <= CHAR_BLANK;
                    activeBuf[b][s] <= CHAR_BLANK;
                end
            end
        end else begin
            readyQ <= 1'b1;
            if (wrFire) begin
                for (int b = 0; b < BOXES; b++) begin
                    for (int s = 0; s < SYMBOLS; s++) begin
                        if (wr_box == BOX_W'(b) && wr_idx == IDX_W'(s)) begin
                            shadowBuf[b][s] <= wr_char;
                        end
                    end
                end
                if (wrInRange) begin
                    dirty <= 1'b1;
                end
            end
            // wr_ready is low in the commit cycle, so a write never races the commit.
            if (commitStrobe && dirty && !freezeIn) begin
                activeBuf <= shadowBuf;
                dirty     <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < BOXES; b++) begin : gBox
        for (genvar s = 0; s < SYMBOLS; s++) begin : gSym
            assign box_chars[(b*SYMBOLS + s)*CHAR_W +: CHAR_W] = activeBuf[b][s];
        end
    end

endmodule
